// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory serving the core's load/store port
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_memory_en,
    input  logic [1:0]  i_store_size,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_write_data,
    output logic [31:0] o_mem_read_data,
    output logic        o_stall_mem,
    output logic        o_mem_err
);
    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT    = 4'(LATENCY);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_load;
    logic          w_misal;
    logic          w_oor;
    logic          w_err;
    logic          w_done;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;

    // Decode the request; stall and read data stay combinational because the core's PC mux depends on them
    always_comb begin
        w_idx           = i_mem_addr[AW+1:2];
        w_lane          = i_mem_addr[1:0];
        w_load          = i_store_size == 2'b11;
        w_misal         = (i_store_size == 2'b01 && w_lane[0]) || (i_store_size == 2'b10 && w_lane != 2'b00);
        w_oor           = {2'b00, i_mem_addr[31:2]} >= 32'(DEPTH_WORDS);
        w_err           = w_misal || w_oor;
        w_done          = i_rst_n && i_memory_en && (r_state == RESP || (r_state == IDLE && LAT == 4'd0));
        w_we            = w_done && !w_load && !w_err;
        w_be            = (i_store_size == 2'b00) ? 4'b0001 << w_lane :
                          (i_store_size == 2'b01) ? 4'b0011 << {w_lane[1], 1'b0} : 4'b1111;
        w_wdata         = i_mem_write_data << {w_lane, 3'b000};
        w_word          = r_mem[w_idx];
        o_mem_read_data = (w_done && w_load && !w_err) ? w_word >> {w_lane, 3'b000} : 32'd0;
        o_mem_err       = w_done && w_err;
        o_stall_mem     = i_rst_n && i_memory_en && (r_state == BUSY || (r_state == IDLE && LAT != 4'd0));
    end

    // Wait-state sequencer: count LATENCY stall cycles, then one completion cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_memory_en && LAT != 4'd0) begin
                        r_cnt   <= 4'd1;
                        r_state <= (LAT == 4'd1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    if (!i_memory_en) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_cnt == LAT_M1) r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table, corner sequences and random traffic against a byte-array model
module tb_data_mem_responder;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en2 = 1'b0, en0 = 1'b0;
    logic [1:0]  sz2 = 2'b11, sz0 = 2'b11;
    logic [31:0] a2 = '0, a0 = '0, wd2 = '0, wd0 = '0;
    logic [31:0] rd2, rd0;
    logic        st2, st0, er2, er0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [2][4*DEPTH];

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_memory_en(en2), .i_store_size(sz2),
        .i_mem_addr(a2), .i_mem_write_data(wd2),
        .o_mem_read_data(rd2), .o_stall_mem(st2), .o_mem_err(er2)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_memory_en(en0), .i_store_size(sz0),
        .i_mem_addr(a0), .i_mem_write_data(wd0),
        .o_mem_read_data(rd0), .o_stall_mem(st0), .o_mem_err(er0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (a[31:2] >= 30'(DEPTH)) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input int z, input logic [31:0] a);
        int b = int'(a) & ~3;
        logic [31:0] w = {mb[z][b+3], mb[z][b+2], mb[z][b+1], mb[z][b]};
        return w >> (8 * (int'(a) % 4));
    endfunction

    task automatic m_store(input int z, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) mb[z][int'(a) + k] = wd[8*k +: 8];
    endtask

    task automatic xfer(input bit z, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int st);
        bit done = 0;
        if (z) begin en0 = 1; sz0 = sz; a0 = a; wd0 = wd; end
        else begin en2 = 1; sz2 = sz; a2 = a; wd2 = wd; end
        st = 0; rd = '0; er = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (z ? st0 : st2) begin
                st++;
                chk("stall_rd_zero", z ? rd0 : rd2, 32'd0);
                chk("stall_err_zero", {31'd0, z ? er0 : er2}, 32'd0);
                @(posedge clk); #1;
            end else begin
                rd = z ? rd0 : rd2;
                er = z ? er0 : er2;
                done = 1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout act=no_completion exp=completion");
        end
        @(posedge clk); #1;
        if (z) en0 = 0; else en2 = 0;
    endtask

    task automatic idle_chk(input bit z);
        @(negedge clk);
        chk("idle_stall", {31'd0, z ? st0 : st2}, 32'd0);
        chk("idle_err", {31'd0, z ? er0 : er2}, 32'd0);
        chk("idle_rd", z ? rd0 : rd2, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, ea, wd;
        logic        er, ee;
        logic [1:0]  sz;
        int          st, r;
        bit          z;

        tbl.push_back('{2'b10, 32'h0000_0000, 32'h0102_0304, 32'h0, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_0020, 32'h0,         32'h0, 1'b0});
        tbl.push_back('{2'b00, 32'h0000_0023, 32'h0000_00AA, 32'h0, 1'b0});
        tbl.push_back('{2'b01, 32'h0000_0020, 32'h0000_1234, 32'h0, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0020, 32'h0,         32'hAA00_1234, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0023, 32'h0,         32'h0000_00AA, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0022, 32'h0,         32'h0000_AA00, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0021, 32'h0,         32'h00AA_0012, 1'b0});
        tbl.push_back('{2'b01, 32'h0000_0021, 32'h0000_BEEF, 32'h0, 1'b1});
        tbl.push_back('{2'b10, 32'h0000_0022, 32'h0000_0099, 32'h0, 1'b1});
        tbl.push_back('{2'b11, 32'h0000_0020, 32'h0,         32'hAA00_1234, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_1000, 32'h0000_0099, 32'h0, 1'b1});
        tbl.push_back('{2'b11, 32'h0000_1000, 32'h0,         32'h0, 1'b1});
        tbl.push_back('{2'b11, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0});
        tbl.push_back('{2'b00, 32'h0000_0001, 32'hFFFF_FF77, 32'h0, 1'b0});
        tbl.push_back('{2'b01, 32'h0000_0002, 32'hFFFF_5566, 32'h0, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0000, 32'h0,         32'h5566_7704, 1'b0});
        tbl.push_back('{2'b10, 32'h0000_0FFC, 32'h1122_3344, 32'h0, 1'b0});
        tbl.push_back('{2'b00, 32'h0000_0FFF, 32'h0000_005A, 32'h0, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0FFC, 32'h0,         32'h5A22_3344, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0FFD, 32'h0,         32'h005A_2233, 1'b0});
        tbl.push_back('{2'b01, 32'h0000_0FFE, 32'h0000_ABCD, 32'h0, 1'b0});
        tbl.push_back('{2'b11, 32'h0000_0FFC, 32'h0,         32'hABCD_3344, 1'b0});

        en2 = 1; sz2 = 2'b10; a2 = 32'h40; wd2 = 32'hCAFE_F00D;
        en0 = 1; sz0 = 2'b10; a0 = 32'h41; wd0 = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_stall2", {31'd0, st2}, 32'd0);
            chk("rst_rd2", rd2, 32'd0);
            chk("rst_stall0", {31'd0, st0}, 32'd0);
            chk("rst_err0", {31'd0, er0}, 32'd0);
        end
        @(posedge clk); #1;
        en0 = 0;
        rst_n = 1;
        xfer(0, 2'b10, 32'h40, 32'hCAFE_F00D, rd, er, st);
        chk("post_rst_stalls", 32'(st), 32'd2);
        chk("post_rst_err", {31'd0, er}, 32'd0);

        foreach (tbl[i]) begin
            xfer(0, tbl[i].sz, tbl[i].a, tbl[i].wd, rd, er, st);
            chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].er});
            chk($sformatf("tbl%0d_stalls", i), 32'(st), 32'd2);
            idle_chk(0);
        end

        xfer(1, 2'b10, 32'h4, 32'h11, rd, er, st);
        chk("lat0_sw_stalls", 32'(st), 32'd0);
        xfer(1, 2'b11, 32'h4, 32'h0, rd, er, st);
        chk("lat0_lw_stalls", 32'(st), 32'd0);
        chk("lat0_lw_rd", rd, 32'h11);
        xfer(1, 2'b01, 32'h21, 32'h0, rd, er, st);
        chk("lat0_mis_err", {31'd0, er}, 32'd1);
        idle_chk(1);

        for (int w = 0; w < 64; w++) begin
            for (int d = 0; d < 2; d++) begin
                wd = $urandom;
                xfer(d[0], 2'b10, 32'(4 * w), wd, rd, er, st);
                m_store(d, 2'b10, 32'(4 * w), wd);
            end
        end

        @(posedge clk); #1;
        en2 = 1; sz2 = 2'b10; a2 = 32'h30; wd2 = 32'h55;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_stall", {31'd0, st2}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_stall", {31'd0, st2}, 32'd0);
        chk("mid_rst_rd", rd2, 32'd0);
        en2 = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        xfer(0, 2'b11, 32'h30, 32'h0, rd, er, st);
        chk("mid_rst_old", rd, m_load(0, 32'h30));

        en2 = 1; sz2 = 2'b10; a2 = 32'h34; wd2 = 32'h77;
        @(posedge clk); #1;
        en2 = 0;
        @(negedge clk);
        chk("abort_stall", {31'd0, st2}, 32'd0);
        @(posedge clk); #1;
        xfer(0, 2'b11, 32'h34, 32'h0, rd, er, st);
        chk("abort_old", rd, m_load(0, 32'h34));
        chk("abort_stalls", 32'(st), 32'd2);

        for (int i = 0; i < 400; i++) begin
            z  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            ea = (r == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) :
                 (r == 1) ? ($urandom | 32'h8000_0000) : 32'($urandom_range(0, 255));
            wd = $urandom;
            ee = m_err(sz, ea);
            xfer(z, sz, ea, wd, rd, er, st);
            chk("rnd_err", {31'd0, er}, {31'd0, ee});
            chk("rnd_rd", rd, (sz == 2'b11 && !ee) ? m_load(int'(z), ea) : 32'd0);
            chk("rnd_stalls", 32'(st), z ? 32'd0 : 32'd2);
            if (sz != 2'b11 && !ee) m_store(int'(z), sz, ea, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port. It accepts the request signals the core drives (memory_en, store_size, mem_addr, mem_write_data) and returns mem_read_data and stall_mem. Each access takes a programmable number of wait cycles, and stall_mem freezes the core's PC and register writes while the access is pending. The block owns a word-organised data array, steers store bytes into the correct lanes, and right-aligns load data. The core performs load sign/zero extension itself.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 2: wait cycles per access (0..15); 0 means single-cycle, no stall.
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- memory_en  input  1  access request from the core; held stable by the core while stall_mem=1.
- store_size  input  2  00 store byte, 01 store half, 10 store word, 11 load.
- mem_addr  input  32  byte address.
- mem_write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_read_data  output  32  load data, right-aligned word containing the addressed byte/half in low bits.
- stall_mem  output  1  core must hold PC/regfile this cycle.
- mem_err  output  1  one-cycle pulse in the completion cycle of a misaligned or out-of-range access.

## Operation
- FSM states: IDLE, BUSY, RESP. Counter cnt is 4 bits.
- IDLE, memory_en=0: stall_mem=0, mem_read_data=0, no action.
- IDLE, memory_en=1, LATENCY=0: this is the completion cycle. stall_mem=0, the read is driven combinationally, the write commits at this edge, and the state stays IDLE.
- IDLE, memory_en=1, LATENCY>0: stall_mem=1 and cnt<=1. Next state is RESP if LATENCY=1, else BUSY.
- BUSY: stall_mem=1 and cnt<=cnt+1. Go to RESP when cnt==LATENCY-1.
- RESP: this is the completion cycle. stall_mem=0, the read result is driven, the write commits at the edge ending RESP, and the next state is IDLE.
- A new memory_en seen in IDLE immediately after RESP starts a fresh access; back-to-back accesses are allowed.
- Word index is mem_addr[log2(DEPTH_WORDS)+1:2]; the byte lane is mem_addr[1:0].
- Stores place mem_write_data into lane(s) by shifting left by 8*mem_addr[1:0]. Only the addressed byte enables are written:
  - byte: one lane;
  - half: lanes {a1,0},{a1,1};
  - word: all four lanes.
- Loads read the addressed word and shift it right by 8*mem_addr[1:0]; upper bits are the shifted-in word bits, not masked.
- Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) or out-of-range access (mem_addr[31:2] ≥ DEPTH_WORDS):
  - no array write;
  - mem_read_data=0;
  - mem_err=1 in the completion cycle only;
  - stall timing unchanged.
- memory_en dropping while BUSY (illegal per protocol): the access is aborted, the next state is IDLE, there is no write, and stall_mem follows the IDLE rules from the next cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, cnt=0;
  - stall_mem=0, mem_read_data=0, mem_err=0, forced immediately regardless of memory_en;
  - a write pending in the same cycle is discarded;
  - array contents are not cleared.
- Reset mid-access: the access is abandoned with no write. After release, the still-asserted memory_en starts a new access from IDLE.
- stall_mem is combinational from state and memory_en, so it is valid in the same cycle the request appears; this is required because the core's PC mux uses it combinationally.
- Access duration: LATENCY stall cycles followed by 1 completion cycle, for a total of LATENCY+1 cycles per access.
- mem_read_data is valid only in the completion cycle and is 0 in every other cycle.
- Read-after-write to the same address in consecutive accesses returns the newly written data.

## Test plan
- Reset: hold rst_n=0 with memory_en=1, store_size=10 -> stall_mem=0, mem_read_data=0; after release, a word store completes with no earlier write visible.
- Word round trip, LATENCY=2: SW 0xDEADBEEF @0x10 -> stall_mem high exactly 2 cycles, completion on cycle 3; then LW @0x10 -> 0xDEADBEEF in its completion cycle.
- Byte/half lanes: SW 0x00000000 @0x20; SB 0x000000AA @0x23; SH 0x00001234 @0x20 -> LW @0x20 = 0xAA001234; LB @0x23 low byte = 0xAA.
- LATENCY=0: back-to-back SW 0x11 @0x4 then LW @0x4 -> stall_mem never asserts, load returns 0x00000011 in the next cycle.
- Misaligned/out-of-range: SH @0x21 and SW @(4*DEPTH_WORDS) -> mem_err pulses once per access in its completion cycle, memory unchanged, read returns 0.
- Reset mid-access: assert rst_n=0 during BUSY of SW 0x55 @0x30 -> subsequent LW @0x30 returns the old contents, not 0x55.
